// File: rtl/n_mode_ring_counter_pkg.sv
// Shared types and seed helper for the n-mode ring counter.
// The optional SELF_CORRECT_EN macro is consumed by n_mode_ring_counter, not here.
package n_mode_ring_counter_pkg;

  typedef enum logic {MODE_RING = 1'b0, MODE_JOHNSON = 1'b1} mode_e;
  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  localparam int unsigned MAX_FLOPS = 64;

  // Ring restarts from a lone 1 in bit 0; Johnson restarts from all zeros.
  function automatic logic [MAX_FLOPS-1:0] seed(input mode_e m, input int unsigned n);
    seed = '0;
    if (m == MODE_RING && n > 0) seed = MAX_FLOPS'(1);
  endfunction

endpackage

// File: rtl/n_ring_legal_chk.sv
// Combinational legality check of the counter state for the active mode.
// Instantiated by n_mode_ring_counter only when SELF_CORRECT_EN is defined.
module n_ring_legal_chk
  import n_mode_ring_counter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] q,
  input  mode_e        mode,
  output logic         legal
);

  logic [N-2:0] edges;

  // A Johnson state has at most one boundary between its run of ones and run of zeros.
  assign edges = q[N-1:1] ^ q[N-2:0];

  always_comb begin
    legal = 1'b0;
    if (mode == MODE_RING) legal = ($countones(q) == 1);
    else                   legal = ($countones(edges) <= 1);
  end

endmodule

// File: rtl/n_mode_ring_counter.sv
// Ring / Johnson shift-register counter with direction, parallel load and wrap pulse.
// Define SELF_CORRECT_EN to add illegal-state correction with an err pulse.
module n_mode_ring_counter
  import n_mode_ring_counter_pkg::*;
#(
  parameter int unsigned NUMBER_OF_FLOPS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stop,
  input  logic                       mode,
  input  logic                       dir,
  input  logic                       load,
  input  logic [NUMBER_OF_FLOPS-1:0] load_val,
  output logic [NUMBER_OF_FLOPS-1:0] q,
  output logic                       q_out,
  output logic                       wrap,
  output logic                       err
);

  localparam int unsigned N = NUMBER_OF_FLOPS;

  logic [N-1:0] q_q, q_d, shift_q, seed_in, seed_reg;
  mode_e        mode_in, mode_q;
  logic         wrap_q, wrap_d, err_q, err_d;
  logic         mode_chg, fix;

  assign mode_in  = mode_e'(mode);
  assign seed_in  = N'(seed(mode_in, N));
  assign seed_reg = N'(seed(mode_q, N));
  assign mode_chg = (mode_in != mode_q);

`ifdef SELF_CORRECT_EN
  logic legal;

  n_ring_legal_chk #(
    .N(N)
  ) u_legal_chk (
    .q    (q_q),
    .mode (mode_q),
    .legal(legal)
  );

  assign fix = !load && !mode_chg && !legal;
`else
  assign fix = 1'b0;
`endif

  always_comb begin
    shift_q = q_q;
    if (mode_q == MODE_RING) begin
      if (dir_e'(dir) == DIR_DOWN) shift_q = {q_q[0], q_q[N-1:1]};
      else                         shift_q = {q_q[N-2:0], q_q[N-1]};
    end else begin
      if (dir_e'(dir) == DIR_DOWN) shift_q = {~q_q[0], q_q[N-1:1]};
      else                         shift_q = {q_q[N-2:0], ~q_q[N-1]};
    end
  end

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      q_d = load_val;
    end else if (mode_chg) begin
      q_d = seed_in;
    end else if (fix) begin
      q_d   = seed_reg;
      err_d = 1'b1;
    end else if (!stop) begin
      q_d    = shift_q;
      wrap_d = (shift_q == seed_reg);
    end
  end

  // Reset seeds from the live mode input so the counter restarts in the requested mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= seed_in;
      mode_q <= mode_in;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      mode_q <= mode_in;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign q     = q_q;
  assign q_out = q_q[N-1];
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule

// File: tb/tb_n_mode_ring_counter.sv
// Directed plus randomized bench for n_mode_ring_counter (N = 4) against an arithmetic model.
// Model and directed expectations follow SELF_CORRECT_EN when it is defined.
module tb_n_mode_ring_counter;

  localparam int N    = 4;
  localparam int MASK = (1 << N) - 1;

  logic         clk, rst, stop, mode, dir, load;
  logic [N-1:0] load_val;
  logic [N-1:0] q;
  logic         q_out, wrap, err;

  int n_assert = 0;
  int n_fail   = 0;

  int q_m, mode_m, wrap_m, err_m;

  n_mode_ring_counter #(
    .NUMBER_OF_FLOPS(N)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .stop    (stop),
    .mode    (mode),
    .dir     (dir),
    .load    (load),
    .load_val(load_val),
    .q       (q),
    .q_out   (q_out),
    .wrap    (wrap),
    .err     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int seed_m(input int m);
    return (m != 0) ? 0 : 1;
  endfunction

  function automatic int shift_m(input int s, input int m, input int d);
    if (m == 0) begin
      if (d == 0) return ((s << 1) | (s >> (N - 1))) & MASK;
      return (s >> 1) | ((s & 1) << (N - 1));
    end
    if (d == 0) return ((s << 1) | ((s >> (N - 1)) ^ 1)) & MASK;
    return (s >> 1) | (((s & 1) ^ 1) << (N - 1));
  endfunction

  function automatic bit legal_m(input int s, input int m);
    int t;
    if (m == 0) return (s != 0) && ((s & (s - 1)) == 0);
    t = (s ^ (s >> 1)) & (MASK >> 1);
    return (t & (t - 1)) == 0;
  endfunction

  // Advance the model with the inputs that the coming edge will sample.
  task automatic model_edge();
    int  nq;
    bit  chg, fx;
    chg    = (int'(mode) != mode_m);
    fx     = 1'b0;
`ifdef SELF_CORRECT_EN
    fx     = !load && !chg && !legal_m(q_m, mode_m);
`endif
    wrap_m = 0;
    err_m  = 0;
    nq     = q_m;
    if (load) nq = int'(load_val);
    else if (chg) nq = seed_m(int'(mode));
    else if (fx) begin
      nq    = seed_m(mode_m);
      err_m = 1;
    end else if (!stop) begin
      nq     = shift_m(q_m, mode_m, int'(dir));
      wrap_m = (nq == seed_m(mode_m)) ? 1 : 0;
    end
    q_m    = nq;
    mode_m = int'(mode);
  endtask

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q"}, q, N'(q_m));
    chk({tag, ".q_out"}, N'(q_out), N'((q_m >> (N - 1)) & 1));
    chk({tag, ".wrap"}, N'(wrap), N'(wrap_m));
    chk({tag, ".err"}, N'(err), N'(err_m));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Called between edges; reset asserts and releases without touching a clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    q_m    = seed_m(int'(mode));
    mode_m = int'(mode);
    wrap_m = 0;
    err_m  = 0;
    check_all(tag);
    rst = 1'b0;
    #1;
  endtask

  logic [N-1:0] johnson_seq [8];

  initial begin
    johnson_seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    rst = 1'b1; stop = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
    #1;
    do_reset("reset");
    chk("reset_const", q, 4'b0001);

    // Ring up, full period.
    for (int i = 0; i < 4; i++) step("ring_up");
    chk("ring_wrap_q", q, 4'b0001);
    chk("ring_wrap", N'(wrap), 4'd1);

    // Johnson: mode change forces seed with no wrap, then 2N shifts.
    mode = 1'b1;
    step("to_johnson");
    chk("johnson_seed", q, 4'b0000);
    chk("johnson_seed_wrap", N'(wrap), 4'd0);
    for (int i = 0; i < 8; i++) begin
      step("johnson_up");
      chk("johnson_seq", q, johnson_seq[i]);
      chk("johnson_wrap", N'(wrap), (i == 7) ? 4'd1 : 4'd0);
    end

    // Ring with in-place direction reversal, then hold.
    mode = 1'b0;
    step("to_ring");
    step("ring_a");
    step("ring_b");
    chk("ring_0100", q, 4'b0100);
    dir = 1'b1;
    step("ring_down1");
    chk("ring_down_0010", q, 4'b0010);
    step("ring_down2");
    chk("ring_down_0001", q, 4'b0001);
    stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step("stop_hold");
      chk("stop_q", q, 4'b0001);
      chk("stop_wrap", N'(wrap), 4'd0);
    end
    stop = 1'b0;
    dir  = 1'b0;

    // Load an illegal ring state.
    load = 1'b1; load_val = 4'b1010;
    step("load_1010");
    chk("load_q", q, 4'b1010);
    load = 1'b0;
    step("illegal_1");
`ifdef SELF_CORRECT_EN
    chk("corrected_q", q, 4'b0001);
    chk("corrected_err", N'(err), 4'd1);
    step("illegal_2");
    chk("err_clear", N'(err), 4'd0);
`else
    chk("circulate_q", q, 4'b0101);
    chk("circulate_err", N'(err), 4'd0);
    step("illegal_2");
    chk("circulate_q2", q, 4'b1010);
`endif

    // Mode toggle while q = 0100.
    load = 1'b1; load_val = 4'b0100;
    step("load_0100");
    load = 1'b0; mode = 1'b1;
    step("toggle_mode");
    chk("toggle_q", q, 4'b0000);
    chk("toggle_wrap", N'(wrap), 4'd0);

    // Load and mode change together: load wins.
    load = 1'b1; load_val = 4'b0110; mode = 1'b0;
    step("load_vs_mode");
    chk("load_wins", q, 4'b0110);
    load = 1'b0;
    step("after_load_mode");

    // Asynchronous reset between edges, just after a wrap.
    load = 1'b1; load_val = 4'b1000;
    step("preload");
    load = 1'b0;
    step("wrap_before_rst");
    @(negedge clk);
    do_reset("mid_reset");
    chk("mid_reset_q", q, 4'b0001);
    chk("mid_reset_wrap", N'(wrap), 4'd0);

    for (int i = 0; i < 400; i++) begin
      stop = ($urandom_range(0, 3) == 0);
      dir  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      load     = ($urandom_range(0, 7) == 0);
      load_val = N'($urandom_range(0, MASK));
      if ($urandom_range(0, 39) == 0) do_reset("rand_reset");
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
